// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. A single full-adder cell and a carry flop walk
// through two WIDTH-bit operands LSB-first, one bit per clock, so a result is
// produced WIDTH clocks after the operands are accepted. Subtraction is done
// as a + ~b + 1, which makes cout a "no borrow" flag in that mode.
//
// Parameters
//   WIDTH     operand/result width in bits (2..64)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, only looked at while busy=0
//   sub       0: a+b+cin, 1: a-b (cin ignored); captured with start
//   a, b      operands, captured on an accepted start
//   cin       carry-in for add mode, captured on an accepted start
//   busy      high while bits are being processed
//   done      one-cycle pulse, result valid
//   sum       result, held until the next completion
//   cout      carry-out (add) / no-borrow (sub)
//   overflow  two's-complement overflow of the result
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             step;
    logic             last;
    logic             bit_sum;
    logic             bit_carry;

    // The one full-adder cell, always looking at the current LSBs and the
    // running carry. During the last bit, 'carry' is the carry into the MSB
    // and 'bit_carry' is the carry out of it, which is what overflow needs.
    assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    // The counter is cleared on accept and has seen WIDTH-1 bits when the
    // final bit is in the adder cell.
    assign last = (cnt == CNT_W'(WIDTH - 1));

    // State register. Reset drops straight back to IDLE, aborting any
    // operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start is only honoured in IDLE, which includes the
    // done cycle, so back-to-back operations run without a gap. RUN lasts
    // exactly WIDTH edges.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode. 'load' captures operands, 'step' advances the
    // serial datapath by one bit. busy is simply "in RUN", so it rises on
    // the accept edge and falls on the final-bit edge.
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        busy = 1'b0;
        case (state)
            IDLE: load = start;
            RUN: begin
                step = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Serial datapath. Operands shift right so the next bit is always at
    // position 0; result bits enter at the MSB end so after WIDTH shifts the
    // first bit computed has reached the LSB. The visible sum/cout/overflow
    // are only written on the final bit, so they stay stable throughout RUN
    // and hold the previous result until then. done is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_sr  <= a;
                b_sr  <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
            end else if (step) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {bit_sum, res_sr[WIDTH-1:1]};
                carry  <= bit_carry;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    sum      <= {bit_sum, res_sr[WIDTH-1:1]};
                    cout     <= bit_carry;
                    overflow <= carry ^ bit_carry;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//
// Scoreboard bench for serial_addsub at WIDTH 8, 2 and 16. Each issued
// operation pushes its arithmetic result (computed from plain integer
// arithmetic) and its accept cycle into a per-instance queue; independent
// monitors pop on every done pulse and compare result flags and latency.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

    typedef struct {
        longint unsigned sum;
        bit              cout;
        bit              ovf;
        longint          c0;
    } exp_t;

    logic clk;
    logic rst_n;
    longint cyc;

    int checks;
    int failures;

    logic        start8, sub8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    logic        start2, sub2, cin2;
    logic [1:0]  a2, b2;
    logic        busy2, done2, cout2, ovf2;
    logic [1:0]  sum2;

    logic        start16, sub16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    exp_t q8[$];
    exp_t q2[$];
    exp_t q16[$];

    longint unsigned lastSum8;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .overflow(ovf8)
    );

    serial_addsub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .overflow(ovf2)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
        .overflow(ovf16)
    );

    // Free-running clock and cycle counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic: unsigned result modulo 2^w, carry/no-borrow from
    // an unsigned comparison, overflow from the signed result leaving range.
    function automatic exp_t computeExpected(input int w, input longint unsigned av,
                                             input longint unsigned bv, input bit s,
                                             input bit c);
        exp_t            e;
        longint unsigned modv;
        longint unsigned tot;
        longint          sa;
        longint          sb;
        longint          r;
        modv = 64'd1 << w;
        sa = (av >= modv / 2) ? longint'(av) - longint'(modv) : longint'(av);
        sb = (bv >= modv / 2) ? longint'(bv) - longint'(modv) : longint'(bv);
        if (s) begin
            e.sum  = (av + modv - bv) % modv;
            e.cout = (av >= bv);
            r      = sa - sb;
        end else begin
            tot    = av + bv + longint'(c);
            e.sum  = tot % modv;
            e.cout = (tot >= modv);
            r      = sa + sb + longint'(c);
        end
        e.ovf = (r >= longint'(modv / 2)) || (r < -longint'(modv / 2));
        e.c0  = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s", name);
    endtask

    // Drives one request into instance k (8, 2 or 16) and, once the accept
    // edge has passed, pushes the expected result with its accept cycle.
    // With hold=1 start is left asserted afterwards.
    task automatic applyStimulus(input int k, input bit s, input longint unsigned av,
                                 input longint unsigned bv, input bit c, input bit hold);
        exp_t e;
        case (k)
            8:  begin a8  = av[7:0];  b8  = bv[7:0];  sub8  = s; cin8  = c; start8  = 1'b1; end
            2:  begin a2  = av[1:0];  b2  = bv[1:0];  sub2  = s; cin2  = c; start2  = 1'b1; end
            default: begin a16 = av[15:0]; b16 = bv[15:0]; sub16 = s; cin16 = c; start16 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        e    = computeExpected(k, av, bv, s, c);
        e.c0 = cyc;
        case (k)
            8:  begin q8.push_back(e);  if (!hold) start8  = 1'b0; end
            2:  begin q2.push_back(e);  if (!hold) start2  = 1'b0; end
            default: begin q16.push_back(e); if (!hold) start16 = 1'b0; end
        endcase
    endtask

    // Issues an operation and advances to the done cycle, so the next call
    // starts exactly when the previous result appears.
    task automatic runOp(input int k, input bit s, input longint unsigned av,
                         input longint unsigned bv, input bit c);
        applyStimulus(k, s, av, bv, c, 1'b0);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Monitors: every done pulse is matched against the oldest outstanding
    // request. The WIDTH=8 monitor also checks the result is stable in RUN.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && busy8) begin
            checkOutput("w8_sum_hold", sum8, lastSum8);
        end
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                reportFail("w8_unexpected_done");
            end else begin
                e = q8.pop_front();
                checkOutput("w8_sum", sum8, e.sum);
                checkOutput("w8_cout", cout8, e.cout);
                checkOutput("w8_overflow", ovf8, e.ovf);
                checkOutput("w8_latency", cyc - e.c0, 8);
                lastSum8 = e.sum;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                reportFail("w2_unexpected_done");
            end else begin
                e = q2.pop_front();
                checkOutput("w2_sum", sum2, e.sum);
                checkOutput("w2_cout", cout2, e.cout);
                checkOutput("w2_overflow", ovf2, e.ovf);
                checkOutput("w2_latency", cyc - e.c0, 2);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                reportFail("w16_unexpected_done");
            end else begin
                e = q16.pop_front();
                checkOutput("w16_sum", sum16, e.sum);
                checkOutput("w16_cout", cout16, e.cout);
                checkOutput("w16_overflow", ovf16, e.ovf);
                checkOutput("w16_latency", cyc - e.c0, 16);
            end
        end
    end

    // Watchdog: a hung run still reports and stops.
    initial begin
        #2000000;
        reportFail("global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

    // Main sequence: reset, directed cases, reset abort, held start, random.
    initial begin
        int busyCount;
        checks   = 0;
        failures = 0;
        lastSum8 = 0;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        start2 = 0; sub2 = 0; cin2 = 0; a2 = 0; b2 = 0;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = 0; b16 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", busy8, 0);
        checkOutput("reset_done", done8, 0);
        checkOutput("reset_sum", sum8, 0);
        checkOutput("reset_cout", cout8, 0);
        checkOutput("reset_overflow", ovf8, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] directed cases");
        applyStimulus(8, 1'b0, 64'h5A, 64'h3C, 1'b0, 1'b0);
        busyCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy8) busyCount++;
        end
        checkOutput("busy_cycles", busyCount, 8);
        @(posedge clk);
        #1;
        runOp(8, 1'b0, 64'hFF, 64'h01, 1'b1);
        runOp(8, 1'b1, 64'h10, 64'h20, 1'b0);
        runOp(8, 1'b1, 64'h80, 64'h01, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset during run");
        applyStimulus(8, 1'b0, 64'h33, 64'h11, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy8, 0);
        checkOutput("abort_done", done8, 0);
        checkOutput("abort_sum", sum8, 0);
        checkOutput("abort_cout", cout8, 0);
        checkOutput("abort_overflow", ovf8, 0);
        void'(q8.pop_back());
        lastSum8 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("after_abort_busy", busy8, 0);

        $display("[TB] held start, operands changing during run");
        applyStimulus(8, 1'b0, 64'h21, 64'h42, 1'b0, 1'b1);
        repeat (8) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            sub8 = 1'($urandom);
            cin8 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        runOp(8, 1'b1, 64'h05, 64'h07, 1'b0);

        $display("[TB] random operations");
        for (int i = 0; i < 200; i++) begin
            runOp(8, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
        end
        for (int i = 0; i < 1000; i++) begin
            runOp(2, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
        for (int i = 0; i < 1000; i++) begin
            runOp(16, 1'($urandom), $urandom_range(0, 65535), $urandom_range(0, 65535), 1'($urandom));
        end
        repeat (20) @(posedge clk);
        #1;

        if (q8.size() != 0)  reportFail("w8_missing_done");
        if (q2.size() != 0)  reportFail("w2_missing_done");
        if (q16.size() != 0) reportFail("w16_missing_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
